// File: rtl/mem_dma.sv
// Byte-wide memory DMA engine: copies a block (read/write pair per byte) or fills
// a block with a constant, walking addresses upward with modulo-256 wrap.
module mem_dma (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] len,
    input  logic [7:0] fill_val,
    input  logic       abort,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_wr_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] xfer_cnt
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t     state;
    logic       mode_q;
    logic [7:0] src_ptr;
    logic [7:0] dst_ptr;
    logic [7:0] remain;
    logic [7:0] fill_q;
    logic [7:0] hold;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            src_ptr  <= 8'h00;
            dst_ptr  <= 8'h00;
            remain   <= 8'h00;
            fill_q   <= 8'h00;
            hold     <= 8'h00;
            xfer_cnt <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        src_ptr  <= src_addr;
                        dst_ptr  <= dst_addr;
                        remain   <= len;
                        fill_q   <= fill_val;
                        xfer_cnt <= 8'h00;
                        if (len == 8'h00)
                            state <= DONE;
                        else if (mode)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    hold  <= mem_rdata;
                    state <= abort ? DONE : WR;
                end
                WR: begin
                    // The write of this cycle commits at this edge even when aborting.
                    xfer_cnt <= xfer_cnt + 8'd1;
                    dst_ptr  <= dst_ptr + 8'd1;
                    if (!mode_q)
                        src_ptr <= src_ptr + 8'd1;
                    remain <= remain - 8'd1;
                    if (abort || remain == 8'd1)
                        state <= DONE;
                    else if (mode_q)
                        state <= WR;
                    else
                        state <= RD;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode purely from registers; no input reaches an output combinationally.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_wr_en = (state == WR);
    assign mem_addr  = (state == RD) ? src_ptr :
                       (state == WR) ? dst_ptr : 8'h00;
    assign mem_wdata = (state == WR && mode_q) ? fill_q : hold;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: behavioural 256-byte memory, write scoreboard,
// and directed copy/fill/len0/overlap/abort/reset scenarios.
module tb_mem_dma;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic [7:0] fill_val;
    logic       abort;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wr_en;
    logic       busy;
    logic       done;
    logic [7:0] xfer_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem     [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic        tb_wr = 1'b0;
    logic [7:0]  tb_waddr = 8'h00;
    logic [7:0]  tb_wdata = 8'h00;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    always #5 clk = ~clk;

    mem_dma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_val  (fill_val),
        .abort     (abort),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt)
    );

    always @(posedge clk) begin
        if (tb_wr)
            mem[tb_waddr] <= tb_wdata;
        else if (rst_n && mem_wr_en)
            mem[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (rst_n && mem_wr_en)
            obs_q.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
        ref_mem[a] = d;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        logic [7:0] sa, da;
        for (int i = 0; i < n; i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            ref_mem[da] = ref_mem[sa];
            exp_q.push_back({da, ref_mem[sa]});
        end
    endtask

    task automatic push_fill(input logic [7:0] d, input int n, input logic [7:0] f);
        logic [7:0] da;
        for (int i = 0; i < n; i++) begin
            da = d + 8'(i);
            ref_mem[da] = f;
            exp_q.push_back({da, f});
        end
    endtask

    task automatic compare_sb(input string tag);
        check({tag, "_nwrites"}, 16'(obs_q.size()), 16'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    // Launch one transfer; cycle numbering counts from the start-accept edge.
    task automatic do_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f, input int abort_wr,
                           input int ghost_cyc, output int done_cyc, output logic [7:0] cnt);
        int wr_seen;
        wr_seen  = 0;
        done_cyc = -1;
        cnt      = 8'hXX;
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start = (c == ghost_cyc);
            if (start) begin
                mode = 1'b1; dst_addr = 8'h40; len = 8'd2; fill_val = 8'hEE;
            end
            abort = 1'b0;
            if (done) begin
                done_cyc = c;
                cnt = xfer_cnt;
                check("done_addr", 16'(mem_addr), 16'h0000);
                check("done_busy", 16'(busy), 16'h0001);
                break;
            end
            if (mem_wr_en) begin
                wr_seen++;
                if (wr_seen == abort_wr) abort = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int         dc;
        int         wr_seen;
        logic [7:0] cnt;
        logic       saw_done;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = 8'h00; dst_addr = 8'h00;
        len = 8'h00; fill_val = 8'h00; abort = 1'b0;
        #2;
        check("rst_busy",  16'(busy),      16'h0000);
        check("rst_done",  16'(done),      16'h0000);
        check("rst_wren",  16'(mem_wr_en), 16'h0000);
        check("rst_addr",  16'(mem_addr),  16'h0000);
        check("rst_wdata", 16'(mem_wdata), 16'h0000);
        check("rst_cnt",   16'(xfer_cnt),  16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Copy four bytes.
        preload(8'h10, 8'hA1); preload(8'h11, 8'hB2);
        preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
        push_copy(8'h10, 8'h80, 4);
        do_xfer(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0, 0, dc, cnt);
        check("copy_done_cyc", 16'(dc), 16'd9);
        check("copy_cnt", 16'(cnt), 16'd4);
        compare_sb("copy");
        check("copy_mem83", 16'(mem[8'h83]), 16'h00D4);

        // Fill with address wrap, plus a start pulsed while busy.
        push_fill(8'hFE, 3, 8'h5A);
        do_xfer(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 0, 2, dc, cnt);
        check("fill_done_cyc", 16'(dc), 16'd4);
        check("fill_cnt", 16'(cnt), 16'd3);
        compare_sb("fill");
        check("fill_mem00", 16'(mem[8'h00]), 16'h005A);
        check("fill_mem01", 16'(mem[8'h01]), 16'h0000);
        repeat (6) @(negedge clk);
        check("ghost_nwrites", 16'(obs_q.size()), 16'h0000);
        check("ghost_busy", 16'(busy), 16'h0000);
        obs_q.delete();

        // Zero length.
        do_xfer(1'b0, 8'h10, 8'h90, 8'd0, 8'h00, 0, 0, dc, cnt);
        check("len0_done_cyc", 16'(dc), 16'd1);
        check("len0_cnt", 16'(cnt), 16'd0);
        compare_sb("len0");

        // Overlapping ascending copy.
        preload(8'h20, 8'h01); preload(8'h21, 8'h02); preload(8'h22, 8'h03);
        push_copy(8'h20, 8'h21, 2);
        do_xfer(1'b0, 8'h20, 8'h21, 8'd2, 8'h00, 0, 0, dc, cnt);
        check("ovl_done_cyc", 16'(dc), 16'd5);
        compare_sb("ovl");
        check("ovl_mem21", 16'(mem[8'h21]), 16'h0001);
        check("ovl_mem22", 16'(mem[8'h22]), 16'h0001);

        // Abort at the edge ending the third WR cycle; next transfer starts in the first IDLE cycle.
        push_copy(8'h10, 8'hA0, 3);
        do_xfer(1'b0, 8'h10, 8'hA0, 8'd10, 8'h00, 3, 0, dc, cnt);
        check("abort_done_cyc", 16'(dc), 16'd7);
        check("abort_cnt", 16'(cnt), 16'd3);
        compare_sb("abort");
        check("abort_mem_a3", 16'(mem[8'hA3]), 16'(ref_mem[8'hA3]));

        // Asynchronous reset after four fill writes.
        push_fill(8'h60, 4, 8'hC3);
        @(negedge clk);
        mode = 1'b1; dst_addr = 8'h60; len = 8'd8; fill_val = 8'hC3; start = 1'b1;
        wr_seen = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_wr_en) wr_seen++;
            if (wr_seen == 5) break;
        end
        check("rst_mid_reached", 16'(wr_seen), 16'd5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy",  16'(busy),      16'h0000);
        check("rst_mid_wren",  16'(mem_wr_en), 16'h0000);
        check("rst_mid_addr",  16'(mem_addr),  16'h0000);
        check("rst_mid_wdata", 16'(mem_wdata), 16'h0000);
        check("rst_mid_cnt",   16'(xfer_cnt),  16'h0000);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("rst_mid_nodone", 16'(saw_done), 16'h0000);
        compare_sb("rst_mid");
        check("rst_mid_mem64", 16'(mem[8'h64]), 16'h0000);

        // Single-byte fill after reset.
        push_fill(8'h70, 1, 8'h99);
        do_xfer(1'b1, 8'h00, 8'h70, 8'd1, 8'h99, 0, 0, dc, cnt);
        check("post_rst_done_cyc", 16'(dc), 16'd2);
        check("post_rst_cnt", 16'(cnt), 16'd1);
        compare_sb("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
